// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and the write/read channel FSM state types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic {
        W_COLLECT = 1'b0,
        W_RESP    = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_ADDR = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4lite_regfile.sv
// Byte-strobed register array with one write port, one async read port and a flattened view.
// Latency: write visible one edge after wr_en; read is combinational.
// Backpressure: none, every write strobe is accepted.
module axi4lite_regfile #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    localparam int STRB_W   = DATA_W / 8,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [STRB_W-1:0]            wr_strb,
    input  logic [DATA_W-1:0]            wr_dat,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic [DATA_W-1:0]            rd_dat,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
    end

    assign rd_dat = regs[rd_idx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed registers, also presented as a flat bus.
// Latency: B one edge after the later of AW/W is captured; R one edge after the AR handshake.
// Backpressure: AW/W/AR ready drop while a response is outstanding until B/R is accepted.
module axi4lite_regfile_slave #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                         A_CLK,
    input  logic                         A_RST,
    input  logic                         AW_VALID,
    output logic                         AW_READY,
    input  logic [ADDR_W-1:0]            AW_ADDR,
    input  logic                         W_VALID,
    output logic                         W_READY,
    input  logic [DATA_W-1:0]            W_DATA,
    input  logic [DATA_W/8-1:0]          W_STRB,
    output logic                         B_VALID,
    input  logic                         B_READY,
    output logic [1:0]                   B_RESP,
    input  logic                         AR_VALID,
    output logic                         AR_READY,
    input  logic [ADDR_W-1:0]            AR_ADDR,
    output logic                         R_VALID,
    input  logic                         R_READY,
    output logic [DATA_W-1:0]            R_DATA,
    output logic [1:0]                   R_RESP,
    output logic [NUM_REGS*DATA_W-1:0]   REGS_OUT
);
    import axi4lite_pkg::*;

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int SEL_W  = ADDR_W - LSB;
    localparam logic [SEL_W:0] REG_LIMIT = (SEL_W+1)'(NUM_REGS);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_txn_t;

    // Extra top bit lets NUM_REGS == 2^SEL_W compare correctly.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr[ADDR_W-1:LSB]} < REG_LIMIT) && (addr[LSB-1:0] == '0);
    endfunction

    wr_state_t         wr_state, wr_state_nxt;
    rd_state_t         rd_state, rd_state_nxt;
    logic              running;
    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              aw_fire, w_fire, ar_fire, b_done, r_done;
    logic              wr_commit, wr_en;
    wr_txn_t           wr_cur;
    logic [DATA_W-1:0] rd_word;

    // running keeps every ready low until the first edge out of reset.
    assign AW_READY = running && (wr_state == W_COLLECT) && !aw_held;
    assign W_READY  = running && (wr_state == W_COLLECT) && !w_held;
    assign AR_READY = running && (rd_state == axi4lite_pkg::R_ADDR);

    assign aw_fire = AW_VALID && AW_READY;
    assign w_fire  = W_VALID && W_READY;
    assign ar_fire = AR_VALID && AR_READY;
    assign b_done  = B_VALID && B_READY;
    assign r_done  = R_VALID && R_READY;

    assign wr_cur.addr = aw_held ? aw_addr_q : AW_ADDR;
    assign wr_cur.data = w_held ? w_data_q : W_DATA;
    assign wr_cur.strb = w_held ? w_strb_q : W_STRB;

    assign wr_commit = (wr_state == W_COLLECT) && (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_en     = wr_commit && addr_legal(wr_cur.addr);

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_COLLECT: if (wr_commit) wr_state_nxt = W_RESP;
            W_RESP:    if (b_done)    wr_state_nxt = W_COLLECT;
            default:                  wr_state_nxt = W_COLLECT;
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            axi4lite_pkg::R_ADDR: if (ar_fire) rd_state_nxt = axi4lite_pkg::R_DATA;
            axi4lite_pkg::R_DATA: if (r_done)  rd_state_nxt = axi4lite_pkg::R_ADDR;
            default:                           rd_state_nxt = axi4lite_pkg::R_ADDR;
        endcase
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            wr_state  <= W_COLLECT;
            rd_state  <= axi4lite_pkg::R_ADDR;
            running   <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            B_VALID   <= 1'b0;
            B_RESP    <= OKAY;
            R_VALID   <= 1'b0;
            R_RESP    <= OKAY;
            R_DATA    <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            running  <= 1'b1;
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= AW_ADDR;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= W_DATA;
                w_strb_q <= W_STRB;
            end
            if (wr_commit) begin
                B_VALID <= 1'b1;
                B_RESP  <= addr_legal(wr_cur.addr) ? OKAY : SLVERR;
            end else if (b_done) begin
                B_VALID <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            // rd_word is sampled before this edge, so a same-edge write is not visible.
            if (ar_fire) begin
                R_VALID <= 1'b1;
                R_DATA  <= addr_legal(AR_ADDR) ? rd_word : '0;
                R_RESP  <= addr_legal(AR_ADDR) ? OKAY : SLVERR;
            end else if (r_done) begin
                R_VALID <= 1'b0;
            end
        end
    end

    axi4lite_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (A_CLK),
        .rst      (A_RST),
        .wr_en    (wr_en),
        .wr_idx   (wr_cur.addr[LSB +: IDX_W]),
        .wr_strb  (wr_cur.strb),
        .wr_dat   (wr_cur.data),
        .rd_idx   (AR_ADDR[LSB +: IDX_W]),
        .rd_dat   (rd_word),
        .regs_out (REGS_OUT)
    );

endmodule

// File: doc/axi4lite_regfile_slave.md
AXI4LITE_REGFILE_SLAVE -- requirements
Module: axi4lite_regfile_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: AW_ADDR/AR_ADDR width in bits.
REQ-002 SHALL have parameter DATA_W, default 32: data width; legal values are 32 or 64.
REQ-003 SHALL have parameter NUM_REGS, default 16: number of DATA_W registers; power of two, 2..2^(ADDR_W-log2(DATA_W/8)).
REQ-004 SHALL have port A_CLK  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port A_RST  in  1  synchronous, active-high reset.
REQ-006 SHALL have port AW_VALID  in  1  write address valid.
REQ-007 SHALL have port AW_READY  out  1  write address ready.
REQ-008 SHALL have port AW_ADDR  in  ADDR_W  write byte address.
REQ-009 SHALL have port W_VALID  in  1  write data valid.
REQ-010 SHALL have port W_READY  out  1  write data ready.
REQ-011 SHALL have port W_DATA  in  DATA_W  write data.
REQ-012 SHALL have port W_STRB  in  DATA_W/8  byte-lane enables.
REQ-013 SHALL have port B_VALID  out  1  write response valid.
REQ-014 SHALL have port B_READY  in  1  write response ready.
REQ-015 SHALL have port B_RESP  out  2  write response.
REQ-016 SHALL have port AR_VALID  in  1  read address valid.
REQ-017 SHALL have port AR_READY  out  1  read address ready.
REQ-018 SHALL have port AR_ADDR  in  ADDR_W  read byte address.
REQ-019 SHALL have port R_VALID  out  1  read data valid.
REQ-020 SHALL have port R_READY  in  1  read data ready.
REQ-021 SHALL have port R_DATA  out  DATA_W  read data.
REQ-022 SHALL have port R_RESP  out  2  read response.
REQ-023 SHALL have port REGS_OUT  out  NUM_REGS*DATA_W  flattened register contents; register i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-024 Register index SHALL be the address bits above log2(DATA_W/8); an address is legal when index < NUM_REGS and low bits are zero; legal -> RESP=OKAY (2'b00), illegal -> RESP=SLVERR (2'b10).
REQ-025 Write FSM SHALL have states W_COLLECT and W_RESP; AW and W SHALL be accepted independently, in either order or the same cycle, each into its own holding register.
REQ-026 In W_COLLECT, AW_READY SHALL be high while no address is held and W_READY high while no data is held; in W_RESP, both SHALL be low.
REQ-027 On the edge at which the second of AW/W is captured (or both together), a legal write SHALL update each byte whose W_STRB bit is set, B_VALID SHALL rise with B_RESP, and the FSM SHALL enter W_RESP.
REQ-028 An illegal write or W_STRB=0 SHALL modify no register; an illegal write SHALL respond SLVERR.
REQ-029 B_VALID and B_RESP SHALL hold until the B_VALID&&B_READY edge; the FSM SHALL then return to W_COLLECT with both holding registers empty.
REQ-030 Read FSM SHALL have states R_ADDR and R_DATA; AR_READY SHALL be high only in R_ADDR.
REQ-031 On the AR handshake edge, R_DATA (register value before any write committing on that same edge; 0 if illegal) and R_RESP SHALL be registered, R_VALID SHALL rise, and the FSM SHALL enter R_DATA.
REQ-032 R_VALID, R_DATA and R_RESP SHALL hold stable until the R_VALID&&R_READY edge, then the FSM SHALL return to R_ADDR; a new AR SHALL NOT be accepted on that edge.
REQ-033 The read and write paths SHALL operate concurrently with no mutual stall.

Reset
REQ-034 While A_RST=1 at an edge, all READY/VALID outputs, B_RESP, R_RESP, R_DATA, all registers and holding registers SHALL be 0, FSMs SHALL be W_COLLECT/R_ADDR; AW_READY, W_READY and AR_READY SHALL rise on the first edge after reset deasserts.
REQ-035 Reset asserted mid-transaction SHALL discard any pending response, with no write committed after that edge.

Structure
REQ-036 A package axi4lite_pkg SHALL hold the RESP constants (OKAY, EXOKAY, SLVERR, DECERR) and the write/read FSM state enums.
REQ-037 Byte-strobed storage SHALL be one sub-module axi4lite_regfile (write port with index/strobe/data, one async read port, flattened output).

Verification
REQ-038 AW 0x04 and W 0xDEADBEEF with STRB 0xF in the same cycle -> B_VALID 1 cycle later with OKAY; read 0x04 -> R_DATA 0xDEADBEEF, OKAY.
REQ-039 W 0x11223344 three cycles before AW 0x08 with STRB 0x5 over 0xFFFFFFFF -> register 2 = 0xFF22FF44; AW_READY low until B handshake.
REQ-040 Write 0x40 or 0x05 (NUM_REGS=16) -> SLVERR, REGS_OUT unchanged; read 0x40 -> R_DATA 0, SLVERR.
REQ-041 B_READY and R_READY held low 5 cycles -> B/R outputs stable, no further AW/W/AR accepted; release -> READY lines return next cycle.
REQ-042 A_RST pulsed while B_VALID=1 and R_VALID=1 -> all outputs 0 next edge, AW_READY/W_READY/AR_READY=1 on the edge after release.
